mem_io_bus: RTL and testbench
=============================

# mem_io_bus

Data-side memory and memory-mapped I/O stage directly downstream of `cpu`. Consumes the CPU's `addressM`, `writeM` and `outM` each cycle and returns `inM`. Address MSB = 0 selects a word-addressed data RAM; MSB = 1 selects an I/O page holding a buffered serial transmitter (TX FIFO plus UART shifter), a status register and an optional cycle counter.

## Interface
- `AddrSize`, `DefaultAddrSize`: RAM address width; bus address width is AddrSize+1.
- `WordSize`, `DefaultWordSize`: data word width; must be ≥ 16.
- `FifoDepth`, 4: TX FIFO entries; power of two, 2..64.
- `BaudDiv`, 4: clock cycles per serial bit; ≥ 2.

- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `addressM`  in  AddrSize+1  CPU data address.
- `writeM`  in  1  write strobe for the current cycle.
- `outM`  in  WordSize  CPU write data.
- `inM`  out  WordSize  read data for `addressM`, combinational.
- `tx`  out  1  serial output; idle high.
- `tx_busy`  out  1  high while a frame is on `tx`.

## Operation
- RAM: 2^AddrSize words. Asynchronous read; write at posedge when `writeM` and MSB = 0. Contents are not cleared by reset.
- I/O offsets use `addressM[AddrSize-1:0]`:
  - 0 TXDATA: a write pushes `outM[7:0]`; reads return 0.
  - 1 STATUS: bit0 empty, bit1 full, bit2 busy, bit3 overflow, bits[8+:log2(FifoDepth)+1] count, all other bits 0. Any write clears overflow.
  - 2 CYCLES: see Configuration.
  - All other offsets read 0 and ignore writes.
- FIFO push when full: the byte is dropped and sticky overflow is set. If a pop occurs in the same cycle, the push is accepted and nothing is dropped.
- Shifter FSM states: IDLE → START → DATA → STOP.
  - Frame: start 0, data[0..7] LSB first, stop 1. Each bit lasts BaudDiv cycles.
  - Pop condition: at a posedge with state IDLE, or at the final cycle of STOP, and FIFO non-empty as of the start of that cycle, the FSM pops and enters START.
  - Back-to-back frames have no idle gap.
  - `tx_busy` = (state ≠ IDLE). In IDLE, `tx` = 1.
- Reset values: FIFO empty, count 0, overflow 0, state IDLE, `tx` = 1, `tx_busy` = 0, cycle counter 0.
- Reset mid-frame aborts the frame and flushes the FIFO. `tx` is 1 from the reset edge onward.

## Timing
- Reads have zero latency: `inM` follows `addressM` combinationally, including STATUS/CYCLES current register values. Written data is visible in the cycle after the write edge.
- TXDATA write to an empty, idle block:
  - Push at edge k; count = 1 after edge k.
  - Pop at edge k+1; `tx` = 0 and `tx_busy` = 1 after edge k+1.
  - Frame occupies 10·BaudDiv cycles; `tx_busy` falls after the last STOP cycle if the FIFO is empty.
- Count is updated after each edge, with push and pop applied together: +1 push only, −1 pop only, unchanged for both or neither.

## Configuration
- `CYCLE_TIMER_EN` defined: CYCLES is a WordSize free-running counter.
  - Increments every clock and wraps 2^WordSize−1 → 0.
  - A write loads `outM`; the write takes precedence over the increment that cycle.
  - Reads return the current value.
- `CYCLE_TIMER_EN` undefined: no counter logic; offset 2 reads 0 and ignores writes.

## Test plan
Bench uses AddrSize = 14, WordSize = 16, FifoDepth = 4, BaudDiv = 4; I/O base is 0x4000.
- RAM: write 0x1234 to address 5, then read address 5 → `inM` = 0x1234 the next cycle. Read 0x4005 → 0.
- Single byte: write 0x0155 to 0x4000 at edge k.
  - `tx` after edge k+1 carries 0,1,0,1,0,1,0,1,0,1, each for 4 cycles (40 cycles total).
  - `tx_busy` is high for exactly 40 cycles; STATUS mid-frame = 0x0005.
- Overflow: write bytes A–F to 0x4000 on six consecutive edges.
  - A pops at edge 2; F is dropped.
  - STATUS after edge 6 = 0x040E.
  - `tx` emits A, B, C, D, E back-to-back with no idle cycle between frames.
  - A write to 0x4001 clears overflow.
- Reset mid-frame: assert `reset` for 1 cycle during DATA with 2 bytes queued → `tx` = 1, `tx_busy` = 0, STATUS = 0x0001 after the reset edge; no further frames are sent.
- Timer with `CYCLE_TIMER_EN`: write 0xFFFE to 0x4002 → reads 0xFFFF, then 0x0000 on successive cycles. Without the macro → 0x4002 reads 0 always.

Source files
------------

// File: rtl/mem_io_bus.sv
// mem_io_bus: data RAM plus a memory-mapped I/O page (buffered UART transmitter,
// status register, optional cycle counter) sitting behind the CPU data port.
// Optional feature macro: CYCLE_TIMER_EN enables the free-running CYCLES counter
// at I/O offset 2; without it that offset reads 0 and ignores writes.
module mem_io_bus #(
  parameter int unsigned AddrSize  = 14,
  parameter int unsigned WordSize  = 16,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned BaudDiv   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AddrSize:0]   addressM,
  input  logic                writeM,
  input  logic [WordSize-1:0] outM,
  output logic [WordSize-1:0] inM,
  output logic                tx,
  output logic                tx_busy
);

  localparam int unsigned PW = $clog2(FifoDepth);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(BaudDiv);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [AddrSize-1:0] OFF_TXDATA = AddrSize'(0);
  localparam logic [AddrSize-1:0] OFF_STATUS = AddrSize'(1);
  localparam logic [AddrSize-1:0] OFF_CYCLES = AddrSize'(2);

  // Address decode
  logic                w_io;
  logic [AddrSize-1:0] w_off;
  logic                w_wr_ram;
  logic                w_wr_tx;
  logic                w_wr_status;

  assign w_io        = addressM[AddrSize];
  assign w_off       = addressM[AddrSize-1:0];
  assign w_wr_ram    = writeM & ~w_io;
  assign w_wr_tx     = writeM & w_io & (w_off == OFF_TXDATA);
  assign w_wr_status = writeM & w_io & (w_off == OFF_STATUS);

  // Data RAM storage (not cleared by reset)
  logic [WordSize-1:0] r_ram [0:(1 << AddrSize)-1];

  // RAM write port
  always_ff @(posedge clk) begin
    if (w_wr_ram) r_ram[w_off] <= outM;
  end

  // TX FIFO state
  logic [7:0]    r_fifo [0:FifoDepth-1];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;

  assign w_empty = (r_count == CW'(0));
  assign w_full  = (r_count == CW'(FifoDepth));
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign w_push  = w_wr_tx & (~w_full | w_pop);
  assign w_drop  = w_wr_tx & w_full & ~w_pop;

  // FIFO byte storage
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= outM[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr_status)  r_ovf <= 1'b0;
      else if (w_drop)  r_ovf <= 1'b1;
    end
  end

  // Shifter state
  logic [1:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;

  logic [1:0]    w_state_nxt;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_tx_nxt;
  logic          w_baud_end;

  assign w_baud_end = (r_baud == BW'(BaudDiv - 1));

  // Shifter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Shifter next state, FIFO pop and next serial bit
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_baud_nxt  = '0;
          w_shift_nxt = r_fifo[r_rptr];
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          // Chain straight into the next frame when a byte is waiting
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_shift_nxt = r_fifo[r_rptr];
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;

  // Cycle counter
  logic [WordSize-1:0] w_cycles;
`ifdef CYCLE_TIMER_EN
  logic                r_cycles_en_wr;
  logic [WordSize-1:0] r_cycles;
  assign r_cycles_en_wr = writeM & w_io & (w_off == OFF_CYCLES);

  // Free-running counter; a bus write overrides the increment
  always_ff @(posedge clk) begin
    if (reset)               r_cycles <= '0;
    else if (r_cycles_en_wr) r_cycles <= outM;
    else                     r_cycles <= r_cycles + WordSize'(1);
  end
  assign w_cycles = r_cycles;
`else
  assign w_cycles = '0;
`endif

  // Status word assembly
  logic [WordSize-1:0] w_status;
  always_comb begin
    w_status          = '0;
    w_status[0]       = w_empty;
    w_status[1]       = w_full;
    w_status[2]       = r_busy;
    w_status[3]       = r_ovf;
    w_status[8 +: CW] = r_count;
  end

  // Zero-latency read mux
  always_comb begin
    inM = '0;
    if (!w_io) begin
      inM = r_ram[w_off];
    end else begin
      case (w_off)
        OFF_STATUS: inM = w_status;
        OFF_CYCLES: inM = w_cycles;
        default:    inM = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_bus.sv
// Testbench for mem_io_bus: bus vector table, serial-frame scoreboard and
// hand-written multi-cycle sequences (single frame, overflow, reset, timer).
module tb_mem_io_bus;

  localparam int unsigned AW = 14;
  localparam int unsigned WW = 16;

  logic          clk;
  logic          reset;
  logic [AW:0]   addressM;
  logic          writeM;
  logic [WW-1:0] outM;
  logic [WW-1:0] inM;
  logic          tx;
  logic          tx_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] byte_q [$];

  mem_io_bus #(.AddrSize(AW), .WordSize(WW), .FifoDepth(4), .BaudDiv(4)) dut (
    .clk(clk), .reset(reset), .addressM(addressM), .writeM(writeM),
    .outM(outM), .inM(inM), .tx(tx), .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [AW:0] a, input logic we, input logic [WW-1:0] d);
    addressM = a;
    writeM   = we;
    outM     = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [AW:0]   addr;
    logic          we;
    logic [WW-1:0] wdata;
    bit            chk;
    logic [WW-1:0] exp;
    string         name;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input logic [AW:0] a, input logic we, input logic [WW-1:0] d,
                         input bit chk, input logic [WW-1:0] e, input string name);
    vec_t v;
    v.addr = a; v.we = we; v.wdata = d; v.chk = chk; v.exp = e; v.name = name;
    vecs.push_back(v);
  endtask

  // Serial monitor: rebuilds each frame and compares it with the expected byte queue
  initial begin : tx_monitor
    logic [7:0] mb;
    logic       stopb;
    bit         ab;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      mb = '0; stopb = 1'b0; ab = 1'b0;
      for (int i = 1; i <= 38; i++) begin
        @(negedge clk);
        if (reset) begin ab = 1'b1; break; end
        if (i >= 6 && i <= 34 && (i % 4) == 2) mb = {tx, mb[7:1]};
        if (i == 38) stopb = tx;
      end
      if (!ab) begin
        if (byte_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_unexpected_frame: got byte 0x%0h expected no frame", mb);
        end else begin
          eb = byte_q.pop_front();
          check("tx_byte", {8'h00, mb}, {8'h00, eb});
          check("tx_stop", {15'h0, stopb}, 16'h0001);
        end
      end
    end
  end

  initial begin : main
    int n;
    int nl;
    logic [7:0] b;

    reset = 1'b1; addressM = '0; writeM = 1'b0; outM = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {15'h0, tx}, 16'h0001);
    check("rst_busy", {15'h0, tx_busy}, 16'h0000);
    reset = 1'b0;

    // Bus vector table
    add_vec(15'h4001, 1'b0, 16'h0000, 1'b1, 16'h0001, "rst_status");
    add_vec(15'h4000, 1'b0, 16'h0000, 1'b1, 16'h0000, "txdata_reads_0");
    add_vec(15'h0005, 1'b1, 16'h1234, 1'b0, 16'h0000, "ram_wr5");
    add_vec(15'h0005, 1'b0, 16'h0000, 1'b1, 16'h1234, "ram_rd5");
    add_vec(15'h3FFF, 1'b1, 16'hBEEF, 1'b0, 16'h0000, "ram_wr_top");
    add_vec(15'h3FFF, 1'b0, 16'h0000, 1'b1, 16'hBEEF, "ram_rd_top");
    add_vec(15'h0005, 1'b0, 16'h0000, 1'b1, 16'h1234, "ram_rd5_again");
    add_vec(15'h4005, 1'b0, 16'h0000, 1'b1, 16'h0000, "io_rd_4005");
    add_vec(15'h4003, 1'b1, 16'hAAAA, 1'b0, 16'h0000, "io_wr_4003");
    add_vec(15'h4003, 1'b0, 16'h0000, 1'b1, 16'h0000, "io_rd_4003");
    add_vec(15'h0000, 1'b1, 16'h7777, 1'b0, 16'h0000, "ram_wr0");
    add_vec(15'h0000, 1'b0, 16'h0000, 1'b1, 16'h7777, "ram_rd0");
    add_vec(15'h4001, 1'b1, 16'hFFFF, 1'b0, 16'h0000, "status_wr");
    add_vec(15'h4001, 1'b0, 16'h0000, 1'b1, 16'h0001, "status_after_wr");
`ifndef CYCLE_TIMER_EN
    add_vec(15'h4002, 1'b1, 16'hFFFE, 1'b0, 16'h0000, "cycles_wr");
    add_vec(15'h4002, 1'b0, 16'h0000, 1'b1, 16'h0000, "cycles_rd0_a");
    add_vec(15'h4002, 1'b0, 16'h0000, 1'b1, 16'h0000, "cycles_rd0_b");
`endif
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].addr, vecs[i].we, vecs[i].wdata);
      if (vecs[i].chk) check(vecs[i].name, inM, vecs[i].exp);
      step();
    end

`ifdef CYCLE_TIMER_EN
    // Timer load and wrap
    drive(15'h4002, 1'b1, 16'hFFFE);
    step();
    drive(15'h4002, 1'b0, 16'h0000);
    check("timer_load", inM, 16'hFFFE);
    step();
    check("timer_max", inM, 16'hFFFF);
    step();
    check("timer_wrap", inM, 16'h0000);
    step();
`endif

    // Single byte frame
    byte_q.push_back(8'h55);
    drive(15'h4000, 1'b1, 16'h0155);
    step();
    drive(15'h4001, 1'b0, 16'h0000);
    check("one_status_k", inM, 16'h0100);
    check("one_tx_k", {15'h0, tx}, 16'h0001);
    check("one_busy_k", {15'h0, tx_busy}, 16'h0000);
    step();
    check("one_tx_start", {15'h0, tx}, 16'h0000);
    check("one_busy_start", {15'h0, tx_busy}, 16'h0001);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (!tx_busy) break;
      n++;
      if (n == 20) check("one_mid_status", inM, 16'h0005);
      step();
    end
    check("one_busy_len", 16'(n), 16'd40);

    // Overflow, push-while-popping and back-to-back frames
    for (int i = 1; i <= 5; i++) byte_q.push_back(8'(8'h40 + i));
    byte_q.push_back(8'h47);
    n = 0;
    for (int e = 1; e <= 400; e++) begin
      if (e <= 6) begin
        b = 8'(8'h40 + e);
        drive(15'h4000, 1'b1, {8'hA5, b});
      end else if (e == 42) begin
        drive(15'h4000, 1'b1, 16'hA547);
      end else begin
        drive(15'h4001, 1'b0, 16'h0000);
      end
      if (e == 7)  check("ovf_status_e6", inM, 16'h040E);
      if (e == 43) check("ovf_status_e42", inM, 16'h040E);
      step();
      if (e == 1) check("ovf_busy_e1", {15'h0, tx_busy}, 16'h0000);
      if (e == 2) check("ovf_busy_e2", {15'h0, tx_busy}, 16'h0001);
      if (tx_busy) n++;
      if (e > 2 && !tx_busy) break;
    end
    check("ovf_busy_total", 16'(n), 16'd240);
    check("ovf_q_drained", 16'(byte_q.size()), 16'd0);
    drive(15'h4001, 1'b0, 16'h0000);
    check("ovf_sticky", inM, 16'h0009);
    step();
    drive(15'h4001, 1'b1, 16'h0000);
    step();
    drive(15'h4001, 1'b0, 16'h0000);
    check("ovf_cleared", inM, 16'h0001);
    step();

    // Reset in the middle of a frame with two bytes queued
    byte_q.push_back(8'h11);
    byte_q.push_back(8'h22);
    byte_q.push_back(8'h33);
    drive(15'h4000, 1'b1, 16'h0011); step();
    drive(15'h4000, 1'b1, 16'h0022); step();
    drive(15'h4000, 1'b1, 16'h0033); step();
    drive(15'h4001, 1'b0, 16'h0000);
    repeat (12) step();
    check("pre_rst_status", inM, 16'h0204);
    reset = 1'b1;
    byte_q.delete();
    step();
    check("rst_mid_tx", {15'h0, tx}, 16'h0001);
    check("rst_mid_busy", {15'h0, tx_busy}, 16'h0000);
    check("rst_mid_status", inM, 16'h0001);
    #1;
    reset = 1'b0;
    n = 0; nl = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (tx_busy) n++;
      if (!tx) nl++;
    end
    check("post_rst_busy_cycles", 16'(n), 16'd0);
    check("post_rst_tx_low_cycles", 16'(nl), 16'd0);
    check("final_q_empty", 16'(byte_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
